// File: rtl/axis_decimator_sched.sv
// ----------------------------------------------------------------------------
// axis_decimator_sched
//
// Shared-decimator scheduler. Several slave AXI-stream sample inputs are
// arbitrated round-robin onto one decimation datapath. Each channel keeps its
// own decimation factor and sample counter. One of every `factor` accepted
// samples of a channel is forwarded to a registered master AXI-stream output,
// tagged with the source channel on m_axis_tdest.
//
// Optional feature macro: DECIMATOR_SCHED_STATS_EN
//   When defined, adds the 16-bit saturating stall_count output. It counts
//   cycles in which the selected channel had a hit that could not be taken
//   because the output register was full. Any cfg_write clears it.
//
// Ports
//   aclk, reset      : clock (rising edge) and asynchronous active-high reset
//   enable           : 1 = samples may be accepted
//   cfg_write        : 1-cycle strobe, writes cfg_factor into cfg_channel
//   cfg_channel      : target channel of the config write (out of range = ignored)
//   cfg_factor       : new decimation factor (0 behaves as 1)
//   s_axis_tdata     : packed inputs, channel k at [k*W +: W]
//   s_axis_tvalid    : per-channel valid
//   s_axis_tready    : per-channel ready, one-hot or zero
//   m_axis_tdata     : decimated sample
//   m_axis_tdest     : source channel of m_axis_tdata
//   m_axis_tvalid    : output valid
//   m_axis_tready    : downstream ready
//   stall_count      : blocked-hit cycle counter (macro builds only)
// ----------------------------------------------------------------------------
module axis_decimator_sched #(
    parameter int axis_data_width        = 32,
    parameter int n_channels             = 4,
    parameter int channel_width          = 2,
    parameter int decimator_factor_width = 8,
    parameter int default_factor         = 10
) (
    input  logic                                  aclk,
    input  logic                                  reset,
    input  logic                                  enable,
    input  logic                                  cfg_write,
    input  logic [channel_width-1:0]              cfg_channel,
    input  logic [decimator_factor_width-1:0]     cfg_factor,
    input  logic [n_channels*axis_data_width-1:0] s_axis_tdata,
    input  logic [n_channels-1:0]                 s_axis_tvalid,
    output logic [n_channels-1:0]                 s_axis_tready,
`ifdef DECIMATOR_SCHED_STATS_EN
    output logic [15:0]                           stall_count,
`endif
    output logic [axis_data_width-1:0]            m_axis_tdata,
    output logic [channel_width-1:0]              m_axis_tdest,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready
);

    localparam int W  = axis_data_width;
    localparam int FW = decimator_factor_width;
    localparam int SW = $clog2(n_channels);

    logic [FW-1:0]         r_factor  [n_channels];
    logic [FW-1:0]         r_counter [n_channels];
    logic [SW-1:0]         r_ptr;
    logic                  r_m_tvalid;
    logic [W-1:0]          r_m_tdata;
    logic [channel_width-1:0] r_m_tdest;

    logic                  w_found;
    logic [SW-1:0]         w_sel;
    logic [FW-1:0]         w_fac_sel;
    logic [FW-1:0]         w_eff_sel;
    logic                  w_hit;
    logic                  w_out_free;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_blocked;
    logic                  w_cfg_valid;
    logic [SW-1:0]         w_cfg_idx;
    logic [SW-1:0]         w_ptr_next;
    logic [W-1:0]          w_sel_data;
    logic [n_channels-1:0] w_tready;

    // Round-robin search: first valid channel at or after the pointer.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_sel   = '0;
        idx     = 0;
        for (int i = 0; i < n_channels; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= n_channels) begin
                idx = idx - n_channels;
            end
            if (!w_found && s_axis_tvalid[SW'(idx)]) begin
                w_found = 1'b1;
                w_sel   = SW'(idx);
            end
        end
    end

    assign w_fac_sel  = r_factor[w_sel];
    assign w_eff_sel  = (w_fac_sel == '0) ? FW'(1) : w_fac_sel;
    assign w_hit      = (r_counter[w_sel] == (w_eff_sel - FW'(1)));
    assign w_out_free = !r_m_tvalid || m_axis_tready;

    // A blocked hit stalls the whole scheduler so it is never bypassed.
    // Reset gating keeps tready low while reset is asserted.
    assign w_accept   = !reset && enable && w_found && (!w_hit || w_out_free);
    assign w_load     = w_accept && w_hit;
    assign w_blocked  = enable && w_found && w_hit && !w_out_free;

    assign w_cfg_valid = cfg_write && (int'(cfg_channel) < n_channels);
    assign w_cfg_idx   = SW'(cfg_channel);
    assign w_ptr_next  = (int'(w_sel) == n_channels - 1) ? '0 : w_sel + SW'(1);
    assign w_sel_data  = s_axis_tdata[int'(w_sel)*W +: W];

    always_comb begin
        w_tready = '0;
        if (w_accept) begin
            w_tready[w_sel] = 1'b1;
        end
    end

    assign s_axis_tready = w_tready;

    // Per-channel factor/counter state; a config write beats a same-cycle accept.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < n_channels; k++) begin
                r_factor[k]  <= FW'(default_factor);
                r_counter[k] <= '0;
            end
            r_ptr <= '0;
        end else begin
            for (int k = 0; k < n_channels; k++) begin
                if (w_cfg_valid && (w_cfg_idx == SW'(k))) begin
                    r_factor[k]  <= cfg_factor;
                    r_counter[k] <= '0;
                end else if (w_accept && (w_sel == SW'(k))) begin
                    r_counter[k] <= w_hit ? '0 : r_counter[k] + FW'(1);
                end
            end
            if (w_accept) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    // Output register: load wins over drain, data held while stalled.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tdest  <= '0;
        end else if (w_load) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_sel_data;
            r_m_tdest  <= channel_width'(w_sel);
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tdest  = r_m_tdest;

`ifdef DECIMATOR_SCHED_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (cfg_write) begin
            r_stall_count <= '0;
        end else if (w_blocked && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`else
    logic w_unused_blocked;
    assign w_unused_blocked = w_blocked;
`endif

endmodule

// File: tb/tb_axis_decimator_sched.sv
module tb_axis_decimator_sched;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int CW = 3;
    localparam int FW = 8;

    logic           aclk;
    logic           reset;
    logic           enable;
    logic           cfg_write;
    logic [CW-1:0]  cfg_channel;
    logic [FW-1:0]  cfg_factor;
    logic [N*W-1:0] s_tdata;
    logic [N-1:0]   s_tvalid;
    logic [N-1:0]   s_tready;
    logic [W-1:0]   m_tdata;
    logic [CW-1:0]  m_tdest;
    logic           m_tvalid;
    logic           m_tready;
`ifdef DECIMATOR_SCHED_STATS_EN
    logic [15:0]    stall_count;
`endif

    int n_chk;
    int n_fail;

    axis_decimator_sched #(
        .axis_data_width        (W),
        .n_channels             (N),
        .channel_width          (CW),
        .decimator_factor_width (FW),
        .default_factor         (10)
    ) dut (
        .aclk          (aclk),
        .reset         (reset),
        .enable        (enable),
        .cfg_write     (cfg_write),
        .cfg_channel   (cfg_channel),
        .cfg_factor    (cfg_factor),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
`ifdef DECIMATOR_SCHED_STATS_EN
        .stall_count   (stall_count),
`endif
        .m_axis_tdata  (m_tdata),
        .m_axis_tdest  (m_tdest),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [31:0] val);
        s_tdata[ch*W +: W] = val;
    endtask

    task automatic cfg(input int ch, input int f);
        cfg_write   = 1'b1;
        cfg_channel = CW'(ch);
        cfg_factor  = FW'(f);
        tick();
        cfg_write   = 1'b0;
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        reset       = 1'b1;
        enable      = 1'b1;
        cfg_write   = 1'b0;
        cfg_channel = '0;
        cfg_factor  = '0;
        s_tdata     = '0;
        s_tvalid    = 4'hF;
        m_tready    = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_tready", 32'(s_tready), 32'h0);
        chk("rst_tvalid", 32'(m_tvalid), 32'h0);
        chk("rst_tdata",  m_tdata,       32'h0);
        chk("rst_tdest",  32'(m_tdest),  32'h0);
        s_tvalid = 4'h0;
        reset    = 1'b0;
        tick();
        chk("rst_idle_tvalid", 32'(m_tvalid), 32'h0);

        // Default factor 10 on ch0: outputs on samples 10, 20, 30
        for (int k = 1; k <= 30; k++) begin
            set_data(0, 32'h1000 + 32'(k));
            s_tvalid = 4'b0001;
            #1;
            chk("s1_rdy", 32'(s_tready), 32'h1);
            tick();
            chk("s1_vld", 32'(m_tvalid), (k % 10 == 0) ? 32'h1 : 32'h0);
            if (k % 10 == 0) begin
                chk("s1_data", m_tdata, 32'h1000 + 32'(k));
                chk("s1_dest", 32'(m_tdest), 32'h0);
            end
        end
        s_tvalid = 4'h0;
        tick();
        chk("s1_drain", 32'(m_tvalid), 32'h0);

        // Round-robin with factor 1 everywhere; pointer sits at 1 after ch0 traffic
        for (int c = 0; c < N; c++) begin
            cfg(c, 1);
            set_data(c, 32'hC0DE0000 + 32'(c));
        end
        for (int j = 0; j < 8; j++) begin
            s_tvalid = 4'hF;
            #1;
            chk("rr_rdy", 32'(s_tready), 32'(1) << ((j + 1) % 4));
            tick();
            chk("rr_vld",  32'(m_tvalid), 32'h1);
            chk("rr_dest", 32'(m_tdest),  32'((j + 1) % 4));
            chk("rr_data", m_tdata,       32'hC0DE0000 + 32'((j + 1) % 4));
        end
        s_tvalid = 4'h0;
        tick();

        // Backpressure: ch1/ch2 factor 2, pointer 1
        cfg(1, 2);
        cfg(2, 2);
        s_tvalid = 4'b0110;
        #1;
        chk("bp_a_rdy", 32'(s_tready), 32'h2);
        tick();
        chk("bp_a_vld", 32'(m_tvalid), 32'h0);
        #1;
        chk("bp_b_rdy", 32'(s_tready), 32'h4);
        tick();
        chk("bp_b_vld", 32'(m_tvalid), 32'h0);
        #1;
        chk("bp_c_rdy", 32'(s_tready), 32'h2);
        tick();
        chk("bp_c_vld",  32'(m_tvalid), 32'h1);
        chk("bp_c_dest", 32'(m_tdest),  32'h1);
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_rdy", 32'(s_tready), 32'h0);
            tick();
            chk("bp_hold_vld",  32'(m_tvalid), 32'h1);
            chk("bp_hold_dest", 32'(m_tdest),  32'h1);
            chk("bp_hold_data", m_tdata,       32'hC0DE0001);
        end
`ifdef DECIMATOR_SCHED_STATS_EN
        chk("bp_stall_count", 32'(stall_count), 32'd5);
`endif
        m_tready = 1'b1;
        #1;
        chk("bp_e_rdy", 32'(s_tready), 32'h4);
        tick();
        chk("bp_e_vld",  32'(m_tvalid), 32'h1);
        chk("bp_e_dest", 32'(m_tdest),  32'h2);
        chk("bp_e_data", m_tdata,       32'hC0DE0002);
        #1;
        chk("bp_f_rdy", 32'(s_tready), 32'h2);
        tick();
        chk("bp_f_vld", 32'(m_tvalid), 32'h0);
        s_tvalid = 4'h0;

        // Config mid-stream: ch0 factor 10, 7 samples, then factor 3
        cfg(0, 10);
        for (int k = 0; k < 7; k++) begin
            set_data(0, 32'h2000 + 32'(k));
            s_tvalid = 4'b0001;
            tick();
            chk("cf_pre_vld", 32'(m_tvalid), 32'h0);
        end
        s_tvalid = 4'h0;
        cfg(0, 3);
        for (int k = 1; k <= 6; k++) begin
            set_data(0, 32'h3000 + 32'(k));
            s_tvalid = 4'b0001;
            tick();
            chk("cf_vld", 32'(m_tvalid), (k % 3 == 0) ? 32'h1 : 32'h0);
            if (k % 3 == 0) begin
                chk("cf_data", m_tdata, 32'h3000 + 32'(k));
            end
        end
        // Config write colliding with a non-hit accept on the same channel
        tick();
        chk("col_pre_vld", 32'(m_tvalid), 32'h0);
        cfg_write   = 1'b1;
        cfg_channel = 3'd0;
        cfg_factor  = 8'd3;
        #1;
        chk("col_rdy", 32'(s_tready), 32'h1);
        tick();
        cfg_write = 1'b0;
        chk("col_vld", 32'(m_tvalid), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("col_post_vld", 32'(m_tvalid), (k == 3) ? 32'h1 : 32'h0);
        end
        s_tvalid = 4'h0;

        // Factor 0 on ch3: every sample forwarded
        cfg(3, 0);
        for (int k = 0; k < 3; k++) begin
            set_data(3, 32'h4000 + 32'(k));
            s_tvalid = 4'b1000;
            tick();
            chk("f0_vld",  32'(m_tvalid), 32'h1);
            chk("f0_dest", 32'(m_tdest),  32'h3);
            chk("f0_data", m_tdata,       32'h4000 + 32'(k));
        end
        s_tvalid = 4'h0;
        // Out-of-range channel 5 must not touch ch1 (counter 1, factor 2)
        cfg(5, 5);
        s_tvalid = 4'b0010;
        tick();
        chk("inv_vld",  32'(m_tvalid), 32'h1);
        chk("inv_dest", 32'(m_tdest),  32'h1);
        s_tvalid = 4'h0;

        // Enable low: ch0 counter 1 of 3 must hold
        s_tvalid = 4'b0001;
        tick();
        chk("en_pre_vld", 32'(m_tvalid), 32'h0);
        s_tvalid = 4'b1000;
        tick();
        chk("en_load_vld", 32'(m_tvalid), 32'h1);
        enable   = 1'b0;
        s_tvalid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("en_off_rdy", 32'(s_tready), 32'h0);
            tick();
            chk("en_off_vld", 32'(m_tvalid), 32'h0);
        end
        enable   = 1'b1;
        s_tvalid = 4'b0001;
        tick();
        chk("en_on1_vld", 32'(m_tvalid), 32'h0);
        tick();
        chk("en_on2_vld",  32'(m_tvalid), 32'h1);
        chk("en_on2_dest", 32'(m_tdest),  32'h0);
        s_tvalid = 4'h0;
        tick();

        // Async reset while output valid
        s_tvalid = 4'b1000;
        tick();
        chk("ar_pre_vld", 32'(m_tvalid), 32'h1);
        s_tvalid = 4'h0;
        reset    = 1'b1;
        #1;
        chk("ar_vld_now", 32'(m_tvalid), 32'h0);
        chk("ar_data_now", m_tdata, 32'h0);
        #2;
        reset = 1'b0;
        tick();
        chk("ar_idle_vld", 32'(m_tvalid), 32'h0);
        for (int k = 1; k <= 10; k++) begin
            set_data(0, 32'h5000 + 32'(k));
            s_tvalid = 4'b0001;
            tick();
            chk("ar_post_vld", 32'(m_tvalid), (k == 10) ? 32'h1 : 32'h0);
        end
        chk("ar_post_data", m_tdata, 32'h500A);
        s_tvalid = 4'h0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
